// File: rtl/accum_expand_pkg.sv
// accum_expand_pkg: default sizes and rail-value helpers shared by the accum_expand slice
package accum_expand_pkg;
  localparam int RI_DEF = 14;
  localparam int N_DEF = 4;
  function automatic int rail_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int rail_lo(input int w);
    return -(1 << (w - 1));
  endfunction
endpackage

// File: rtl/accum_expand_if.sv
// accum_expand_if: sample stream in, widened window sum out (rail_hits live only with ACCUM_RAILCNT_EN)
interface accum_expand_if
  import accum_expand_pkg::*;
#(
  parameter int Ri = RI_DEF,
  parameter int N = N_DEF
);
  logic clr;
  logic signed [Ri-1:0] in;
  logic in_vld;
  logic signed [Ri+N-1:0] out;
  logic out_vld;
  logic [N:0] rail_hits;
  modport master(output clr, in, in_vld, input out, out_vld, rail_hits);
  modport slave(input clr, in, in_vld, output out, out_vld, rail_hits);
endinterface

// File: rtl/accum_railcnt.sv
// accum_railcnt: counts rail-valued samples per window, latched at window completion
module accum_railcnt
  import accum_expand_pkg::*;
#(
  parameter int Ri = RI_DEF,
  parameter int N = N_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 acc_en,
  input  logic                 last,
  input  logic signed [Ri-1:0] in,
  output logic        [N:0]    rail_hits
);
  logic [N:0] run, nxt;
  logic hit;
  always_comb begin
    hit = in == Ri'(rail_hi(Ri)) || in == Ri'(rail_lo(Ri));
    nxt = run + (N+1)'(hit);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run <= '0;
      rail_hits <= '0;
    end else if (clr) begin
      run <= '0;
    end else if (acc_en) begin
      run <= last ? '0 : nxt;
      if (last) rail_hits <= nxt;
    end
  end
endmodule

// File: rtl/accum_expand.sv
// accum_expand: exact 2^N-sample windowed sum of a signed stream; ACCUM_RAILCNT_EN adds rail counting
module accum_expand
  import accum_expand_pkg::*;
#(
  parameter int Ri = RI_DEF,
  parameter int N = N_DEF
) (
  input logic clk,
  input logic rst,
  accum_expand_if.slave bus
);
  localparam int Ro = Ri + N;
  localparam int CW = N > 0 ? N : 1;
  logic signed [Ro-1:0] acc, sum;
  logic [CW-1:0] cnt;
  logic acc_en, last;
  // With N=0 the counter never leaves 0, so every accepted sample completes a window
  always_comb begin
    acc_en = bus.in_vld && !bus.clr;
    last = cnt == CW'((1 << N) - 1);
    sum = (cnt == '0 ? '0 : acc) + Ro'(bus.in);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
      bus.out <= '0;
      bus.out_vld <= 1'b0;
    end else begin
      bus.out_vld <= 1'b0;
      if (bus.clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (acc_en) begin
        acc <= sum;
        cnt <= last ? '0 : cnt + CW'(1);
        if (last) bus.out <= sum;
        bus.out_vld <= last;
      end
    end
  end
`ifdef ACCUM_RAILCNT_EN
  accum_railcnt #(.Ri(Ri), .N(N)) u_railcnt (
    .clk(clk),
    .rst(rst),
    .clr(bus.clr),
    .acc_en(acc_en),
    .last(last),
    .in(bus.in),
    .rail_hits(bus.rail_hits)
  );
`else
  assign bus.rail_hits = '0;
`endif
endmodule

// File: tb/tb_accum_expand.sv
// tb_accum_expand: directed and random checks of accum_expand (Ri=14, N=2 and N=0) against a queue model
module tb_accum_expand;
`ifdef ACCUM_RAILCNT_EN
  localparam bit RAIL = 1'b1;
`else
  localparam bit RAIL = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  int win[$];
  logic m_vld = 1'b0;
  logic signed [15:0] m_out = '0;
  logic [2:0] m_rail = '0;

  accum_expand_if #(.Ri(14), .N(2)) b();
  accum_expand_if #(.Ri(14), .N(0)) b0();
  accum_expand #(.Ri(14), .N(2)) dut (.clk(clk), .rst(rst), .bus(b));
  accum_expand #(.Ri(14), .N(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  always #5 clk = ~clk;

  task automatic model_reset();
    win.delete();
    m_vld = 1'b0;
    m_out = '0;
    m_rail = '0;
  endtask

  task automatic step(input int x, input bit v, input bit c);
    int s, r;
    b.in = 14'(x);
    b.in_vld = v;
    b.clr = c;
    @(posedge clk);
    #1;
    m_vld = 1'b0;
    if (c) win.delete();
    else if (v) begin
      win.push_back(x);
      if (win.size() == 4) begin
        s = 0;
        r = 0;
        foreach (win[i]) begin
          s += win[i];
          if (win[i] == 8191 || win[i] == -8192) r++;
        end
        m_out = 16'(s);
        m_rail = RAIL ? 3'(r) : 3'd0;
        m_vld = 1'b1;
        win.delete();
      end
    end
  endtask

  task automatic test_reset();
    b.in = '0; b.in_vld = 1'b0; b.clr = 1'b0;
    b0.in = '0; b0.in_vld = 1'b0; b0.clr = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({b.out_vld, b.out, b.rail_hits} !== 20'd0) begin
      failures++;
      $display("FAIL reset vld=%0b out=%0d rail=%0d exp 0/0/0", b.out_vld, b.out, b.rail_hits);
    end
    checks++;
    if ({b0.out_vld, b0.out, b0.rail_hits} !== 16'd0) begin
      failures++;
      $display("FAIL reset_n0 vld=%0b out=%0d rail=%0d exp 0/0/0", b0.out_vld, b0.out, b0.rail_hits);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic run_seq(input string nm, input int xs[$], input int gap);
    foreach (xs[i]) begin
      step(xs[i], 1'b1, 1'b0);
      checks++;
      if ({b.out_vld, b.out, b.rail_hits} !== {m_vld, m_out, m_rail}) begin
        failures++;
        $display("FAIL %s vld=%0b out=%0d rail=%0d exp vld=%0b out=%0d rail=%0d",
                 nm, b.out_vld, b.out, b.rail_hits, m_vld, m_out, m_rail);
      end
      for (int g = 0; g < gap; g++) begin
        step(0, 1'b0, 1'b0);
        checks++;
        if ({b.out_vld, b.out, b.rail_hits} !== {m_vld, m_out, m_rail}) begin
          failures++;
          $display("FAIL %s_gap vld=%0b out=%0d rail=%0d exp vld=%0b out=%0d rail=%0d",
                   nm, b.out_vld, b.out, b.rail_hits, m_vld, m_out, m_rail);
        end
      end
    end
  endtask

  task automatic test_basic();
    run_seq("basic", '{100, 200, -50, 10}, 0);
    checks++;
    if (b.out !== 16'sd260 || b.out_vld !== 1'b1) begin
      failures++;
      $display("FAIL basic_260 out=%0d vld=%0b exp out=260 vld=1", b.out, b.out_vld);
    end
    run_seq("basic_hold", '{}, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1'b0, 1'b0);
      checks++;
      if (b.out !== 16'sd260 || b.out_vld !== 1'b0) begin
        failures++;
        $display("FAIL basic_held out=%0d vld=%0b exp out=260 vld=0", b.out, b.out_vld);
      end
    end
  endtask

  task automatic test_clr();
    run_seq("clr_pre", '{5, 5}, 0);
    step(5, 1'b1, 1'b1);
    checks++;
    if (b.out !== 16'sd260 || b.out_vld !== 1'b0) begin
      failures++;
      $display("FAIL clr_hold out=%0d vld=%0b exp out=260 vld=0", b.out, b.out_vld);
    end
    run_seq("clr_post", '{1, 1, 1, 1}, 0);
    checks++;
    if (b.out !== 16'sd4 || b.out_vld !== 1'b1) begin
      failures++;
      $display("FAIL clr_4 out=%0d vld=%0b exp out=4 vld=1", b.out, b.out_vld);
    end
  endtask

  task automatic test_rails();
    run_seq("rail_lo", '{-8192, -8192, -8192, -8192}, 0);
    checks++;
    if (b.out !== -16'sd32768 || b.rail_hits !== (RAIL ? 3'd4 : 3'd0)) begin
      failures++;
      $display("FAIL rail_lo_val out=%0d rail=%0d exp out=-32768 rail=%0d", b.out, b.rail_hits, RAIL ? 4 : 0);
    end
    run_seq("rail_hi", '{8191, 8191, 8191, 8191}, 0);
    checks++;
    if (b.out !== 16'sd32764 || b.rail_hits !== (RAIL ? 3'd4 : 3'd0)) begin
      failures++;
      $display("FAIL rail_hi_val out=%0d rail=%0d exp out=32764 rail=%0d", b.out, b.rail_hits, RAIL ? 4 : 0);
    end
  endtask

  task automatic test_gapped();
    run_seq("gapped", '{1, 2, 3, 4}, 2);
    checks++;
    if (b.out !== 16'sd10) begin
      failures++;
      $display("FAIL gapped_10 out=%0d exp out=10", b.out);
    end
  endtask

  task automatic test_reset_mid();
    run_seq("rstmid_pre", '{9, 9}, 0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({b.out_vld, b.out, b.rail_hits} !== 20'd0) begin
      failures++;
      $display("FAIL rstmid_async vld=%0b out=%0d rail=%0d exp 0/0/0", b.out_vld, b.out, b.rail_hits);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    run_seq("rstmid_post", '{7, 7, 7, 7}, 0);
    checks++;
    if (b.out !== 16'sd28) begin
      failures++;
      $display("FAIL rstmid_28 out=%0d exp out=28", b.out);
    end
  endtask

  task automatic test_n0();
    int xs[4] = '{3, -3, 0, 8191};
    bit vs[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic signed [13:0] e_out = '0;
    logic e_rail = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b0.in = 14'(xs[i]);
      b0.in_vld = vs[i];
      @(posedge clk);
      #1;
      if (vs[i]) begin
        e_out = 14'(xs[i]);
        e_rail = RAIL && (xs[i] == 8191 || xs[i] == -8192);
      end
      checks++;
      if ({b0.out_vld, b0.out, b0.rail_hits} !== {vs[i], e_out, e_rail}) begin
        failures++;
        $display("FAIL n0_%0d vld=%0b out=%0d rail=%0d exp vld=%0b out=%0d rail=%0b",
                 i, b0.out_vld, b0.out, b0.rail_hits, vs[i], e_out, e_rail);
      end
    end
    b0.in_vld = 1'b0;
  endtask

  task automatic test_random();
    int x;
    int r;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      x = r == 0 ? 8191 : r == 1 ? -8192 : int'($urandom_range(0, 16383)) - 8192;
      step(x, $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
      checks++;
      if ({b.out_vld, b.out, b.rail_hits} !== {m_vld, m_out, m_rail}) begin
        failures++;
        $display("FAIL random_%0d vld=%0b out=%0d rail=%0d exp vld=%0b out=%0d rail=%0d",
                 i, b.out_vld, b.out, b.rail_hits, m_vld, m_out, m_rail);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clr();
    test_rails();
    test_gapped();
    test_reset_mid();
    test_n0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout exp finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
